// File: rtl/fa_pkg.sv
// fa_pkg: shared definitions for the registered full-adder cell.
//   fa_sum / fa_carry : single-bit full-adder equations
//   FA_RST_S / FA_RST_C : output register values after reset
package fa_pkg;

    localparam logic FA_RST_S = 1'b0;
    localparam logic FA_RST_C = 1'b0;

    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// fa_cell: purely combinational single-bit full adder.
//   A, B  : addend bits
//   C_in  : carry-in
//   S     : sum bit
//   C     : carry-out
module fa_cell
    import fa_pkg::*;
(
    input  logic A,
    input  logic B,
    input  logic C_in,
    output logic S,
    output logic C
);

    always_comb begin
        S = fa_sum(A, B, C_in);
        C = fa_carry(A, B, C_in);
    end

endmodule

// File: rtl/fa_unit.sv
// fa_unit: registered single-bit full adder, leaf cell for ripple and
// bit-serial adders. Result and valid flag appear one clock after an
// accepted input; S and C hold while in_valid is low.
//
// Build option: define FA_SERIAL_EN to let 'serial' select the registered
// carry as the carry-in (bit-serial addition). Without it 'serial' is
// ignored and the carry-in is always C_in.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   qualifies A, B, C_in and serial
//   A, B       addend bits
//   C_in       external carry-in
//   serial     1 = use registered carry as carry-in (FA_SERIAL_EN only)
//   S, C       registered sum and carry-out
//   out_valid  single-cycle pulse: S/C updated at the last edge
module fa_unit
    import fa_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic A,
    input  logic B,
    input  logic C_in,
    input  logic serial,
    output logic S,
    output logic C,
    output logic out_valid
);

    logic s_q, s_d;
    logic c_q, c_d;
    logic valid_q, valid_d;
    logic cin_eff;
    logic sum_w;
    logic carry_w;

`ifdef FA_SERIAL_EN
    // The carry register doubles as the bit-serial carry state, so a gap
    // in in_valid keeps the chain intact and reset restarts it from 0.
    assign cin_eff = serial ? c_q : C_in;
`else
    logic unused_serial;
    assign unused_serial = serial;
    assign cin_eff       = C_in;
`endif

    fa_cell u_cell (
        .A    (A),
        .B    (B),
        .C_in (cin_eff),
        .S    (sum_w),
        .C    (carry_w)
    );

    always_comb begin
        s_d     = s_q;
        c_d     = c_q;
        valid_d = in_valid;
        if (in_valid) begin
            s_d = sum_w;
            c_d = carry_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= FA_RST_S;
            c_q     <= FA_RST_C;
            valid_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            c_q     <= c_d;
            valid_q <= valid_d;
        end
    end

    assign S         = s_q;
    assign C         = c_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_fa_unit.sv
// tb_fa_unit: directed bench for fa_unit. A behavioural model computes the
// expected registered result as the integer A + B + carry-in; a compare
// process checks S, C and out_valid against it every cycle after reset.
// Literal expectations from hand-worked tables pin the model.
// Works with or without FA_SERIAL_EN defined.
module tb_fa_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic a_i = 1'b0;
    logic b_i = 1'b0;
    logic cin_i = 1'b0;
    logic serial_i = 1'b0;
    logic s_o;
    logic c_o;
    logic valid_o;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fa_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (a_i),
        .B         (b_i),
        .C_in      (cin_i),
        .serial    (serial_i),
        .S         (s_o),
        .C         (c_o),
        .out_valid (valid_o)
    );

    // Behavioural model: result = A + B + carry-in as an integer.
    logic m_s = 1'b0;
    logic m_c = 1'b0;
    logic m_v = 1'b0;
    logic m_ready = 1'b0;

    always @(posedge clk) begin
        int cin;
        int total;
        if (rst) begin
            m_s     <= 1'b0;
            m_c     <= 1'b0;
            m_v     <= 1'b0;
            m_ready <= 1'b1;
        end else if (in_valid) begin
`ifdef FA_SERIAL_EN
            cin = serial_i ? int'(m_c) : int'(cin_i);
`else
            cin = int'(cin_i);
`endif
            total = int'(a_i) + int'(b_i) + cin;
            m_s <= (total % 2) == 1;
            m_c <= total >= 2;
            m_v <= 1'b1;
        end else begin
            m_v <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            n_vec++;
            if (s_o !== m_s || c_o !== m_c || valid_o !== m_v) begin
                n_bad++;
                $display("FAIL model_cmp t=%0t: got C=%b S=%b v=%b, expected C=%b S=%b v=%b",
                         $time, c_o, s_o, valid_o, m_c, m_s, m_v);
            end
        end
    end

    // Drive one cycle of inputs, then return just after the edge that
    // consumed them so outputs reflect that edge.
    task automatic apply(input logic r, input logic v, input logic a, input logic b,
                         input logic ci, input logic ser);
        rst      = r;
        in_valid = v;
        a_i      = a;
        b_i      = b;
        cin_i    = ci;
        serial_i = ser;
        @(posedge clk);
        #1;
    endtask

    task automatic check_lit(input string name, input logic ec, input logic es, input logic ev);
        n_vec++;
        if (c_o !== ec || s_o !== es || valid_o !== ev) begin
            n_bad++;
            $display("FAIL %s: got C=%b S=%b v=%b, expected C=%b S=%b v=%b",
                     name, c_o, s_o, valid_o, ec, es, ev);
        end
    endtask

    initial begin
        logic [1:0] exp_tab [8];
        logic [2:0] abc;
        exp_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        // Reset state
        apply(1, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        check_lit("reset", 1'b0, 1'b0, 1'b0);

        // Exhaustive table, back-to-back
        for (int i = 0; i < 8; i++) begin
            abc = 3'(i);
            apply(0, 1, abc[2], abc[1], abc[0], 0);
            check_lit($sformatf("exh_%0d", i), exp_tab[i][1], exp_tab[i][0], 1'b1);
        end

        // Reset overrides in_valid
        apply(1, 1, 1, 1, 1, 0);
        check_lit("rst_prio", 1'b0, 1'b0, 1'b0);

        // Hold while idle with toggling inputs
        apply(0, 1, 1, 1, 0, 0);
        check_lit("hold_load", 1'b1, 1'b0, 1'b1);
        apply(0, 0, 0, 0, 1, 1);
        check_lit("hold_1", 1'b1, 1'b0, 1'b0);
        apply(0, 0, 1, 0, 0, 0);
        check_lit("hold_2", 1'b1, 1'b0, 1'b0);
        apply(0, 0, 0, 1, 1, 1);
        check_lit("hold_3", 1'b1, 1'b0, 1'b0);

`ifdef FA_SERIAL_EN
        // 0111 + 0011 LSB-first -> S bits 0,1,0,1 (=10), final C=0
        apply(1, 0, 0, 0, 0, 0);
        apply(0, 1, 1, 1, 0, 1);
        check_lit("ser_b0", 1'b1, 1'b0, 1'b1);
        apply(0, 1, 1, 1, 0, 1);
        check_lit("ser_b1", 1'b1, 1'b1, 1'b1);
        apply(0, 1, 1, 0, 0, 1);
        check_lit("ser_b2", 1'b1, 1'b0, 1'b1);
        apply(0, 1, 0, 0, 0, 1);
        check_lit("ser_b3", 1'b0, 1'b1, 1'b1);

        // Same add with an idle cycle after bit 1
        apply(1, 0, 0, 0, 0, 0);
        apply(0, 1, 1, 1, 0, 1);
        check_lit("gap_b0", 1'b1, 1'b0, 1'b1);
        apply(0, 1, 1, 1, 0, 1);
        check_lit("gap_b1", 1'b1, 1'b1, 1'b1);
        apply(0, 0, 0, 0, 0, 1);
        check_lit("gap_idle", 1'b1, 1'b1, 1'b0);
        apply(0, 1, 1, 0, 0, 1);
        check_lit("gap_b2", 1'b1, 1'b0, 1'b1);
        apply(0, 1, 0, 0, 0, 1);
        check_lit("gap_b3", 1'b0, 1'b1, 1'b1);

        // Reset mid-chain: carry restarts from 0
        apply(0, 1, 1, 1, 0, 1);
        check_lit("mid_pre", 1'b1, 1'b0, 1'b1);
        apply(1, 0, 0, 0, 0, 0);
        apply(0, 1, 1, 0, 1, 1);
        check_lit("mid_post", 1'b0, 1'b1, 1'b1);
`else
        // Feedback absent: serial=1 has no effect
        apply(0, 1, 1, 1, 0, 1);
        check_lit("nofb_1", 1'b1, 1'b0, 1'b1);
        apply(0, 1, 1, 1, 0, 1);
        check_lit("nofb_2", 1'b1, 1'b0, 1'b1);
`endif

        // Mixed traffic checked by the model only
        for (int i = 0; i < 40; i++) begin
            apply(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        apply(0, 0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
